// File: rtl/silent_lpf_pkg.sv
// Shared types and latency helper for the silent LPF stage and its sequencer.
package silent_lpf_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WARMUP   = 2'd1,
    IDLE     = 2'd2,
    RUN      = 2'd3
  } state_t;

  // Cycles from an accepted START until the LPF is back in IDLE.
  function automatic int unsigned busy_cycles(input int unsigned depth);
    return 2 * depth + 10;
  endfunction

endpackage

// File: rtl/silent_lpf_sched_tick_gen.sv
// Update-interval counter: clamps/samples PERIOD, merges SYNC with the natural wrap.
module period_tick_gen #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned MIN_PERIOD   = 509
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE_IN,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic                    SYNC,
  output logic                    TICK
);

  localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(MIN_PERIOD);

  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] p_eff;
  logic [PERIOD_WIDTH-1:0] p_clamp;
  logic                    wrap;

  assign p_clamp = (PERIOD < P_MIN) ? P_MIN : PERIOD;
  assign wrap    = (cnt == p_eff - PERIOD_WIDTH'(1));

  // Position 0 of the grid is the tick; SYNC makes the current cycle position 0.
  assign TICK = ENABLE_IN && (SYNC || (cnt == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      p_eff <= P_MIN;
    end else if (!ENABLE_IN) begin
      cnt <= '0;
    end else begin
      if (TICK) p_eff <= p_clamp;
      if (SYNC)      cnt <= PERIOD_WIDTH'(1);
      else if (wrap) cnt <= '0;
      else           cnt <= cnt + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/silent_lpf_sched.sv
// Silent-mode LPF sequencer: periodic START/STEP issue, busy tracking, overrun count, ENABLE gating.
module silent_lpf_sched
  import silent_lpf_pkg::*;
#(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned DEPTH        = 249,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned BUSY_CYCLES  = busy_cycles(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE_IN,
  input  logic [WIDTH-1:0]        STEP_IN,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic                    SYNC,
  output logic                    LPF_START,
  output logic [WIDTH-1:0]        LPF_STEP,
  output logic                    LPF_ENABLE,
  output logic                    BUSY,
  output logic [15:0]             OVERRUN_CNT
);

  localparam int unsigned BW = $clog2(BUSY_CYCLES + 1);

  state_t          state, state_d;
  logic [BW-1:0]   busy_cnt, busy_cnt_d;
  logic            drain, drain_d;
  logic            tick;
  logic            issue;
  logic            expire;
  logic            lpf_enable_d;

  period_tick_gen #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .MIN_PERIOD   (BUSY_CYCLES + 1)
  ) u_tick_gen (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE_IN (ENABLE_IN),
    .PERIOD    (PERIOD),
    .SYNC      (SYNC),
    .TICK      (tick)
  );

  assign expire = (busy_cnt == BW'(1));

  // Next state; drain remembers an ENABLE_IN drop while a pass is still in flight.
  always_comb begin
    state_d      = state;
    drain_d      = drain;
    issue        = 1'b0;
    lpf_enable_d = LPF_ENABLE && ENABLE_IN;
    busy_cnt_d   = (busy_cnt != '0) ? busy_cnt - BW'(1) : '0;
    case (state)
      DISABLED: begin
        if (ENABLE_IN) begin
          issue   = 1'b1;
          drain_d = 1'b0;
          state_d = WARMUP;
        end
      end
      WARMUP, RUN: begin
        if (!ENABLE_IN) drain_d = 1'b1;
        if (expire) begin
          drain_d = 1'b0;
          if (drain || !ENABLE_IN) begin
            state_d = DISABLED;
          end else begin
            state_d = IDLE;
            if (state == WARMUP) lpf_enable_d = 1'b1;
          end
        end
      end
      IDLE: begin
        if (!ENABLE_IN) begin
          state_d = DISABLED;
        end else if (tick) begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = DISABLED;
    endcase
    if (issue) busy_cnt_d = BW'(BUSY_CYCLES);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= DISABLED;
      drain       <= 1'b0;
      busy_cnt    <= '0;
      LPF_START   <= 1'b0;
      LPF_STEP    <= '0;
      LPF_ENABLE  <= 1'b0;
      BUSY        <= 1'b0;
      OVERRUN_CNT <= '0;
    end else begin
      state      <= state_d;
      drain      <= drain_d;
      busy_cnt   <= busy_cnt_d;
      LPF_START  <= issue;
      LPF_ENABLE <= lpf_enable_d;
      BUSY       <= (busy_cnt_d != '0);
      if (issue) LPF_STEP <= STEP_IN;
      // A tick landing while busy (including its last cycle) is dropped and counted.
      if (tick && BUSY && (OVERRUN_CNT != 16'hFFFF))
        OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_silent_lpf_sched.sv
// Directed bench for silent_lpf_sched at default parameters (BUSY_CYCLES=508).
module tb_silent_lpf_sched;

  localparam int unsigned WIDTH = 13;
  localparam int unsigned PW    = 16;

  logic             clk;
  logic             rst;
  logic             enable_in;
  logic [WIDTH-1:0] step_in;
  logic [PW-1:0]    period;
  logic             sync;
  logic             lpf_start;
  logic [WIDTH-1:0] lpf_step;
  logic             lpf_enable;
  logic             busy;
  logic [15:0]      overrun_cnt;

  int cyc;
  int errors;
  int checks;
  int at;

  silent_lpf_sched dut (
    .CLK         (clk),
    .RST         (rst),
    .ENABLE_IN   (enable_in),
    .STEP_IN     (step_in),
    .PERIOD      (period),
    .SYNC        (sync),
    .LPF_START   (lpf_start),
    .LPF_STEP    (lpf_step),
    .LPF_ENABLE  (lpf_enable),
    .BUSY        (busy),
    .OVERRUN_CNT (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick_clk();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance until LPF_START is seen or the limit cycle is reached; -1 if none.
  task automatic find_start(input int limit, output int found);
    found = -1;
    while (cyc < limit && found < 0) begin
      tick_clk();
      if (lpf_start === 1'b1) found = cyc;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    enable_in = 1'b0;
    sync      = 1'b0;
    step_in   = WIDTH'(40);
    period    = PW'(1000);
    cyc       = -3;
    go_to(0);

    chk("rst_start",   32'(lpf_start),   0);
    chk("rst_step",    32'(lpf_step),    0);
    chk("rst_enable",  32'(lpf_enable),  0);
    chk("rst_busy",    32'(busy),        0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    rst = 1'b0;

    go_to(10);
    enable_in = 1'b1;
    find_start(20, at);
    chk("warmup_start_cycle", 32'(at), 11);
    chk("warmup_step",        32'(lpf_step), 40);
    chk("warmup_busy",        32'(busy), 1);
    chk("warmup_enable_low",  32'(lpf_enable), 0);
    go_to(12);
    chk("start_one_cycle", 32'(lpf_start), 0);
    go_to(518);
    chk("busy_last",        32'(busy), 1);
    chk("enable_pre_rise",  32'(lpf_enable), 0);
    go_to(519);
    chk("busy_done",        32'(busy), 0);
    chk("enable_rise",      32'(lpf_enable), 1);

    go_to(600);
    step_in = WIDTH'(7);
    chk("step_held", 32'(lpf_step), 40);
    find_start(1100, at);
    chk("second_start_cycle", 32'(at), 1011);
    chk("step_updated",       32'(lpf_step), 7);
    go_to(1012);
    chk("second_start_pulse", 32'(lpf_start), 0);

    go_to(1310);
    sync = 1'b1;
    go_to(1311);
    sync = 1'b0;
    chk("sync_overrun", 32'(overrun_cnt), 1);
    chk("sync_no_start", 32'(lpf_start), 0);
    find_start(2400, at);
    chk("post_sync_start", 32'(at), 2311);

    period = PW'(100);
    find_start(3400, at);
    chk("clamp_start0", 32'(at), 3311);
    find_start(3900, at);
    chk("clamp_start1", 32'(at), 3820);
    find_start(4400, at);
    chk("clamp_start2", 32'(at), 4329);
    chk("clamp_no_overrun", 32'(overrun_cnt), 1);

    go_to(4836);
    chk("last_busy_cycle", 32'(busy), 1);
    sync = 1'b1;
    go_to(4837);
    chk("last_cycle_overrun", 32'(overrun_cnt), 2);
    chk("idle_after_pass",    32'(busy), 0);
    go_to(4838);
    sync = 1'b0;
    chk("sync_idle_start",    32'(lpf_start), 1);
    chk("sync_idle_overrun",  32'(overrun_cnt), 2);

    go_to(5037);
    enable_in = 1'b0;
    go_to(5038);
    chk("drop_enable_fall", 32'(lpf_enable), 0);
    chk("drop_busy_held",   32'(busy), 1);
    go_to(5345);
    chk("drop_busy_last",   32'(busy), 1);
    go_to(5346);
    chk("drop_busy_done",   32'(busy), 0);
    find_start(6000, at);
    chk("drop_no_start",    32'(at), 32'hFFFF_FFFF);

    enable_in = 1'b1;
    find_start(6100, at);
    chk("rewarm_start_cycle", 32'(at), 6001);
    chk("rewarm_enable_low",  32'(lpf_enable), 0);
    go_to(6508);
    chk("rewarm_pre_rise",    32'(lpf_enable), 0);
    go_to(6509);
    chk("rewarm_rise",        32'(lpf_enable), 1);
    find_start(6600, at);
    chk("rewarm_next_start",  32'(at), 6510);

    go_to(6700);
    chk("pre_rst_overrun", 32'(overrun_cnt), 2);
    chk("pre_rst_busy",    32'(busy), 1);
    rst       = 1'b1;
    enable_in = 1'b0;
    go_to(6701);
    chk("midrun_rst_start",   32'(lpf_start),   0);
    chk("midrun_rst_step",    32'(lpf_step),    0);
    chk("midrun_rst_enable",  32'(lpf_enable),  0);
    chk("midrun_rst_busy",    32'(busy),        0);
    chk("midrun_rst_overrun", 32'(overrun_cnt), 0);
    rst = 1'b0;
    go_to(6705);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/silent_lpf_sched.md
# silent_lpf_sched

Sequencer for the silent low-pass filter stage of the transducer datapath. It issues periodic one-cycle START pulses to the LPF at a programmable update interval and holds STEP stable for each whole LPF pass. It tracks LPF busy time with a cycle counter, counts dropped (overrun) updates, and gates the LPF's ENABLE. ENABLE rises only after the first full pass completes, so the transducer outputs never switch to an uninitialised filter buffer.

## Interface
- WIDTH, 13: duty/phase/step width; must match the LPF.
- DEPTH, 249: transducer count; must match the LPF.
- PERIOD_WIDTH, 16: width of the update-interval register.
- BUSY_CYCLES, 2*DEPTH+10: cycles from accepted START until the LPF returns to IDLE (508 at default).
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- ENABLE_IN  in  1  silent mode requested (config register).
- STEP_IN  in  WIDTH  requested per-pass step limit.
- PERIOD  in  PERIOD_WIDTH  update interval in CLK cycles.
- SYNC  in  1  one-cycle pulse; realigns the update grid.
- LPF_START  out  1  one-cycle start pulse to the LPF.
- LPF_STEP  out  WIDTH  step value driven to the LPF.
- LPF_ENABLE  out  1  ENABLE to the LPF (output mux select).
- BUSY  out  1  LPF pass in progress.
- OVERRUN_CNT  out  16  saturating count of ticks dropped because BUSY was high.

## Operation
- Reset values: LPF_START=0, LPF_STEP=0, LPF_ENABLE=0, BUSY=0, OVERRUN_CNT=0. State is DISABLED and the tick counter is 0.
- Effective period: P = max(PERIOD, BUSY_CYCLES+1). PERIOD is sampled only at counter wrap or on SYNC.
- Tick generator:
  - The counter counts 0..P-1 while ENABLE_IN=1. It is held at 0 while ENABLE_IN=0.
  - A tick fires in the cycle the counter wraps to 0.
  - SYNC forces the counter to 0 and fires a tick in that cycle.
  - SYNC and a natural wrap in the same cycle produce a single tick.
- States:
  - DISABLED: waits for ENABLE_IN=1. On that cycle it fires an immediate tick and goes to WARMUP.
  - WARMUP: first pass in flight; LPF_ENABLE=0. When the busy counter expires it goes to IDLE and sets LPF_ENABLE=1.
  - IDLE: on a tick it issues a pass and goes to RUN.
  - RUN: on busy-counter expiry it returns to IDLE.
  - ENABLE_IN=0 in any state: LPF_ENABLE drops to 0 on the next cycle and no new START is issued. Any in-flight pass runs to completion (BUSY stays valid), then the block goes to DISABLED.
- Issuing a pass: STEP_IN is latched into LPF_STEP, LPF_START pulses, and the busy counter loads BUSY_CYCLES. LPF_STEP holds until the next issue.
- Overrun: a tick arriving while BUSY=1 is dropped, not queued. OVERRUN_CNT increments and saturates at 16'hFFFF. OVERRUN_CNT clears only on RST.
- A tick in the last BUSY cycle counts as an overrun.

## Timing
- A tick at cycle t gives LPF_START=1 at t+1. LPF_STEP is valid from t+1.
- BUSY is 1 for cycles t+1..t+BUSY_CYCLES inclusive.
- LPF_ENABLE rises at t+BUSY_CYCLES+1 after the WARMUP issue, one cycle after the LPF output buffer updates.
- LPF_ENABLE falls one cycle after ENABLE_IN falls.
- OVERRUN_CNT updates one cycle after the dropped tick.
- RST mid-pass forces all outputs to reset values immediately. The LPF finishes its pass autonomously; the next enable always goes through WARMUP.

## Structure
- The package silent_lpf_pkg holds:
  - the state enum {DISABLED, WARMUP, IDLE, RUN};
  - the BUSY_CYCLES default as a function of DEPTH, shared with the LPF so latency stays consistent.
- Sub-module period_tick_gen contains the counter, PERIOD sampling and clamping, and the SYNC/wrap merge. It outputs TICK.
- The top level contains the FSM, busy counter, STEP shadow and overrun counter.

## Test plan
All cases use the defaults (BUSY_CYCLES=508) and PERIOD=1000 unless stated.
- RST released, ENABLE_IN=1 at cycle 10, STEP_IN=40:
  - LPF_START at 11 with LPF_STEP=40.
  - BUSY over 11..518; LPF_ENABLE rises at 519.
  - Next START at 1011.
- STEP_IN changed to 7 at cycle 600 (mid-period):
  - LPF_STEP stays 40 until the START at 1011, then becomes 7.
- PERIOD=100 (below the minimum): START spacing is exactly 509 cycles and OVERRUN_CNT stays 0.
- SYNC pulses at cycle 300 while BUSY:
  - OVERRUN_CNT becomes 1 and no START is issued.
  - The next START comes 1000 cycles after the SYNC.
- ENABLE_IN dropped at cycle 200 of a pass:
  - LPF_ENABLE falls next cycle and BUSY completes its 508 cycles.
  - No further START; re-enabling repeats the WARMUP timing.
- RST asserted mid-RUN: every output is 0 on the next cycle, including OVERRUN_CNT and LPF_STEP.
